// File: rtl/hazard_ctrl_if.sv
// Purpose: ID-stage instruction and EX redirect into the hazard unit; stall/flush controls and debug state out.
// Latency: none, plain wires.
// Backpressure: o_stall is the hold applied to PC and IF/ID; there is no other flow control.
//
// Signals:
//   i_instr_ID    instruction sitting in ID (IF/ID output), 0 = bubble
//   i_br_taken_EX EX-stage redirect (taken branch, JAL, JALR)
//   o_stall       hold PC and IF/ID
//   o_flush_IF_ID clear IF/ID on the next edge
//   o_flush_ID_EX bubble into ID/EX on the next edge
//   o_sb_valid    scoreboard valid bits {WB,MEM,EX}
//   o_stall_cnt   saturating count of stall cycles
//   o_flush_cnt   saturating count of redirect cycles
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      i_instr_ID;
    logic             i_br_taken_EX;
    logic             o_stall;
    logic             o_flush_IF_ID;
    logic             o_flush_ID_EX;
    logic [2:0]       o_sb_valid;
    logic [CNT_W-1:0] o_stall_cnt;
    logic [CNT_W-1:0] o_flush_cnt;

    // pipeline side: drives the ID instruction and redirect, consumes controls
    modport master (
        output i_instr_ID,
        output i_br_taken_EX,
        input  o_stall,
        input  o_flush_IF_ID,
        input  o_flush_ID_EX,
        input  o_sb_valid,
        input  o_stall_cnt,
        input  o_flush_cnt
    );

    // hazard unit side
    modport slave (
        input  i_instr_ID,
        input  i_br_taken_EX,
        output o_stall,
        output o_flush_IF_ID,
        output o_flush_ID_EX,
        output o_sb_valid,
        output o_stall_cnt,
        output o_flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Purpose: stall/flush generator for a non-forwarding 5-stage RV32I pipeline, tracking in-flight rd in EX/MEM/WB.
// Latency: stall/flush outputs are combinational from the scoreboard and the ID instruction; scoreboard moves each edge.
// Backpressure: a RAW hazard holds PC and IF/ID and bubbles ID/EX; an EX redirect overrides the hold and flushes both.
//
// Ports:
//   i_clk    core clock
//   i_rst_n  asynchronous active-low reset (clears scoreboard and counters)
//   hz       hazard_ctrl_if.slave: i_instr_ID, i_br_taken_EX in; o_stall, o_flush_IF_ID,
//            o_flush_ID_EX, o_sb_valid, o_stall_cnt, o_flush_cnt out
// Parameters:
//   WB_WRITE_FIRST  1 = regfile writes before reads, so the WB slot never causes a hazard
//   CNT_W           width of the performance counters
module hazard_ctrl_unit #(
    parameter int WB_WRITE_FIRST = 1,
    parameter int CNT_W          = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    hazard_ctrl_if.slave hz
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam bit               CHECK_WB = (WB_WRITE_FIRST == 0);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // instruction fields
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;

    assign opcode = hz.i_instr_ID[6:0];
    assign rd     = hz.i_instr_ID[11:7];
    assign rs1    = hz.i_instr_ID[19:15];
    assign rs2    = hz.i_instr_ID[24:20];

    // funct3/funct7 play no part in hazard detection
    logic unused_instr_bits;
    assign unused_instr_bits = ^{hz.i_instr_ID[31:25], hz.i_instr_ID[14:12]};

    logic uses_rs1;
    logic uses_rs2;
    logic wr_class;
    logic writes_rd;

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        wr_class = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                wr_class = 1'b1;
            end
            OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
                uses_rs1 = 1'b1;
                wr_class = 1'b1;
            end
            OPC_BRANCH, OPC_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_OP: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                wr_class = 1'b1;
            end
            default: begin
                uses_rs1 = 1'b0;
                uses_rs2 = 1'b0;
                wr_class = 1'b0;
            end
        endcase
    end

    // writes to x0 are discarded by the regfile, so they never occupy a slot
    assign writes_rd = wr_class && (rd != 5'd0);

    // scoreboard slots mirroring EX/MEM/WB
    logic       ex_vld;
    logic [4:0] ex_rd;
    logic       mem_vld;
    logic [4:0] mem_rd;
    logic       wb_vld;
    logic [4:0] wb_rd;

    logic rs1_hit;
    logic rs2_hit;
    logic hazard;
    logic issue;

    always_comb begin
        rs1_hit = (rs1 != 5'd0) &&
                  ((ex_vld  && (ex_rd  == rs1)) ||
                   (mem_vld && (mem_rd == rs1)) ||
                   (CHECK_WB && wb_vld && (wb_rd == rs1)));
        rs2_hit = (rs2 != 5'd0) &&
                  ((ex_vld  && (ex_rd  == rs2)) ||
                   (mem_vld && (mem_rd == rs2)) ||
                   (CHECK_WB && wb_vld && (wb_rd == rs2)));
    end

    assign hazard = (uses_rs1 && rs1_hit) || (uses_rs2 && rs2_hit);
    // a redirect discards the ID instruction, so it must not enter EX even without a hazard
    assign issue  = !hazard && !hz.i_br_taken_EX;

    assign hz.o_stall       = hazard && !hz.i_br_taken_EX;
    assign hz.o_flush_IF_ID = hz.i_br_taken_EX;
    assign hz.o_flush_ID_EX = hazard || hz.i_br_taken_EX;
    assign hz.o_sb_valid    = {wb_vld, mem_vld, ex_vld};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ex_vld  <= 1'b0;
            ex_rd   <= 5'd0;
            mem_vld <= 1'b0;
            mem_rd  <= 5'd0;
            wb_vld  <= 1'b0;
            wb_rd   <= 5'd0;
        end else begin
            // the redirecting instruction is already past EX entry and keeps moving
            ex_vld  <= issue && writes_rd;
            ex_rd   <= rd;
            mem_vld <= ex_vld;
            mem_rd  <= ex_rd;
            wb_vld  <= mem_vld;
            wb_rd   <= mem_rd;
        end
    end

    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hz.o_stall && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (hz.i_br_taken_EX && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

    assign hz.o_stall_cnt = stall_cnt;
    assign hz.o_flush_cnt = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Purpose: self-checking bench for hazard_ctrl_unit in three configurations (write-first, WB-checked, 4-bit counters).
// Latency: expectations are per cycle; each cycle's response is queued at stimulus time and checked on the falling edge.
// Backpressure: the bench pipeline holds its ID instruction while the reference model says the unit stalls.
module tb_hazard_ctrl_unit;
    localparam int ND   = 3;
    localparam int LOGN = 4096;

    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] OPIMM = 7'b0010011;

    logic i_clk;
    logic i_rst_n;
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    hazard_ctrl_if #(.CNT_W(32)) if0 ();
    hazard_ctrl_if #(.CNT_W(32)) if1 ();
    hazard_ctrl_if #(.CNT_W(4))  if2 ();

    hazard_ctrl_unit #(.WB_WRITE_FIRST(1), .CNT_W(32)) dut0 (.i_clk(i_clk), .i_rst_n(i_rst_n), .hz(if0));
    hazard_ctrl_unit #(.WB_WRITE_FIRST(0), .CNT_W(32)) dut1 (.i_clk(i_clk), .i_rst_n(i_rst_n), .hz(if1));
    hazard_ctrl_unit #(.WB_WRITE_FIRST(1), .CNT_W(4))  dut2 (.i_clk(i_clk), .i_rst_n(i_rst_n), .hz(if2));

    logic [31:0] instr   [ND];
    logic        br      [ND];
    logic        stall_o [ND];
    logic        fif_o   [ND];
    logic        fie_o   [ND];
    logic [2:0]  sbv_o   [ND];
    logic [31:0] scnt_o  [ND];
    logic [31:0] fcnt_o  [ND];

    assign if0.i_instr_ID = instr[0];
    assign if1.i_instr_ID = instr[1];
    assign if2.i_instr_ID = instr[2];
    assign if0.i_br_taken_EX = br[0];
    assign if1.i_br_taken_EX = br[1];
    assign if2.i_br_taken_EX = br[2];
    assign stall_o[0] = if0.o_stall;
    assign stall_o[1] = if1.o_stall;
    assign stall_o[2] = if2.o_stall;
    assign fif_o[0] = if0.o_flush_IF_ID;
    assign fif_o[1] = if1.o_flush_IF_ID;
    assign fif_o[2] = if2.o_flush_IF_ID;
    assign fie_o[0] = if0.o_flush_ID_EX;
    assign fie_o[1] = if1.o_flush_ID_EX;
    assign fie_o[2] = if2.o_flush_ID_EX;
    assign sbv_o[0] = if0.o_sb_valid;
    assign sbv_o[1] = if1.o_sb_valid;
    assign sbv_o[2] = if2.o_sb_valid;
    assign scnt_o[0] = if0.o_stall_cnt;
    assign scnt_o[1] = if1.o_stall_cnt;
    assign scnt_o[2] = {28'd0, if2.o_stall_cnt};
    assign fcnt_o[0] = if0.o_flush_cnt;
    assign fcnt_o[1] = if1.o_flush_cnt;
    assign fcnt_o[2] = {28'd0, if2.o_flush_cnt};

    // Reference model: a per-cycle history of which destination register entered
    // the pipeline (0 = nothing). A source is blocked if it was written by an
    // instruction issued within the last "window" cycles.
    logic [4:0]  dlog    [ND][LOGN];
    int          cyc;
    int          floor_c;
    logic [31:0] sc_exp  [ND];
    logic [31:0] fc_exp  [ND];
    logic [31:0] cnt_max [ND];
    bit          issue_d [ND];
    bit          stall_d [ND];
    bit          br_d    [ND];
    logic [4:0]  wd_d    [ND];
    bit          adv     [ND];
    bit          rst_now;
    logic [31:0] plist [$];
    int          pidx  [ND];
    int          n_cmp;
    int          n_bad;

    typedef struct {
        int          d;
        bit          stall;
        bit          fif;
        bit          fie;
        logic [2:0]  sbv;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;
    exp_t expq [$];
    exp_t mon_e;

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, op};
    endfunction

    function automatic void decode(input logic [31:0] ins, output bit u1, output bit u2, output logic [4:0] wd);
        logic [6:0] op;
        op = ins[6:0];
        u1 = op inside {7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
        u2 = op inside {7'b1100011, 7'b0100011, 7'b0110011};
        wd = (op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                         7'b0000011, 7'b0010011, 7'b0110011}) ? ins[11:7] : 5'd0;
    endfunction

    function automatic bit in_flight(input int d, input logic [4:0] r);
        int win;
        win = (d == 1) ? 3 : 2;
        if (r == 5'd0) return 1'b0;
        for (int k = 1; k <= win; k++) begin
            if (cyc - k >= floor_c) begin
                if (dlog[d][(cyc - k) % LOGN] == r) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [12];
        logic [31:0] w;
        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
                7'b0100011, 7'b0010011, 7'b0110011, 7'b0110011, 7'b1110011, 7'b0000000};
        w = $urandom;
        w[6:0]   = ops[$urandom_range(0, 11)];
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s dut%0d cyc %0d: got %0h, required %0h", nm, d, cyc, act, req);
        end
    endtask

    task automatic model_clear();
        floor_c = cyc;
        for (int d = 0; d < ND; d++) begin
            sc_exp[d] = 32'd0;
            fc_exp[d] = 32'd0;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < ND; d++) begin
            if (rst_now) begin
                dlog[d][cyc % LOGN] = 5'd0;
            end else begin
                dlog[d][cyc % LOGN] = issue_d[d] ? wd_d[d] : 5'd0;
                if (stall_d[d] && sc_exp[d] != cnt_max[d]) sc_exp[d] = sc_exp[d] + 32'd1;
                if (br_d[d] && fc_exp[d] != cnt_max[d]) fc_exp[d] = fc_exp[d] + 32'd1;
            end
        end
        cyc++;
    endtask

    task automatic predict(input int d);
        bit         u1;
        bit         u2;
        bit         hzd;
        logic [4:0] wd;
        exp_t       e;
        decode(instr[d], u1, u2, wd);
        hzd = (u1 && in_flight(d, instr[d][19:15])) || (u2 && in_flight(d, instr[d][24:20]));
        e.d     = d;
        e.stall = hzd && !br[d];
        e.fif   = br[d];
        e.fie   = hzd || br[d];
        for (int k = 0; k < 3; k++) begin
            e.sbv[k] = 1'b0;
            if (cyc - 1 - k >= floor_c) e.sbv[k] = (dlog[d][(cyc - 1 - k) % LOGN] != 5'd0);
        end
        e.sc = sc_exp[d];
        e.fc = fc_exp[d];
        expq.push_back(e);
        issue_d[d] = !hzd && !br[d];
        stall_d[d] = e.stall;
        br_d[d]    = br[d];
        wd_d[d]    = wd;
        adv[d]     = !rst_now && (issue_d[d] || br[d]);
    endtask

    task automatic new_prog();
        for (int d = 0; d < ND; d++) begin
            pidx[d] = 0;
            adv[d]  = 1'b1;
        end
    endtask

    // mode 1: reset asserted mid-stall with immediate checks; mode 2: redirect during a hazard
    task automatic run_phase(input int ncyc, input int rst_at, input int rst_len,
                             input int br_at, input bit rnd, input int mode);
        for (int k = 0; k < ncyc; k++) begin
            @(posedge i_clk);
            model_edge();
            #1;
            if (rst_len > 0 && k == rst_at + rst_len) i_rst_n = 1'b1;
            rst_now = (rst_len > 0) && (k >= rst_at) && (k < rst_at + rst_len);
            if (rst_now) model_clear();
            for (int d = 0; d < ND; d++) begin
                if (adv[d]) begin
                    if (pidx[d] < plist.size()) begin
                        instr[d] = plist[pidx[d]];
                        pidx[d]++;
                    end else begin
                        instr[d] = rnd ? rand_instr() : 32'd0;
                    end
                end
                br[d] = (k == br_at) || (rnd && ($urandom_range(0, 7) == 0));
                predict(d);
            end
            if (rst_len > 0 && k == rst_at) begin
                #1;
                if (mode == 1)
                    for (int d = 0; d < ND; d++) chk("stall_before_reset", d, 32'(stall_o[d]), 32'd1);
                #1;
                i_rst_n = 1'b0;
                #1;
                if (mode == 1) begin
                    for (int d = 0; d < ND; d++) begin
                        chk("reset_stall", d, 32'(stall_o[d]), 32'd0);
                        chk("reset_flush_id_ex", d, 32'(fie_o[d]), 32'd0);
                        chk("reset_sb_valid", d, 32'(sbv_o[d]), 32'd0);
                        chk("reset_stall_cnt", d, scnt_o[d], 32'd0);
                        chk("reset_flush_cnt", d, fcnt_o[d], 32'd0);
                    end
                end
            end
            if (mode == 2 && k == br_at) begin
                #1;
                for (int d = 0; d < ND; d++) begin
                    chk("redirect_stall", d, 32'(stall_o[d]), 32'd0);
                    chk("redirect_flush_if_id", d, 32'(fif_o[d]), 32'd1);
                    chk("redirect_flush_id_ex", d, 32'(fie_o[d]), 32'd1);
                end
            end
            if (mode == 2 && k == br_at + 1) begin
                #1;
                for (int d = 0; d < ND; d++) chk("redirect_ex_slot", d, 32'(sbv_o[d][0]), 32'd0);
            end
        end
    endtask

    always @(negedge i_clk) begin
        while (expq.size() > 0) begin
            mon_e = expq.pop_front();
            chk("stall", mon_e.d, 32'(stall_o[mon_e.d]), 32'(mon_e.stall));
            chk("flush_if_id", mon_e.d, 32'(fif_o[mon_e.d]), 32'(mon_e.fif));
            chk("flush_id_ex", mon_e.d, 32'(fie_o[mon_e.d]), 32'(mon_e.fie));
            chk("sb_valid", mon_e.d, 32'(sbv_o[mon_e.d]), 32'(mon_e.sbv));
            chk("stall_cnt", mon_e.d, scnt_o[mon_e.d], mon_e.sc);
            chk("flush_cnt", mon_e.d, fcnt_o[mon_e.d], mon_e.fc);
        end
    end

    initial begin
        i_rst_n = 1'b0;
        n_cmp   = 0;
        n_bad   = 0;
        cyc     = 0;
        floor_c = 0;
        rst_now = 1'b1;
        for (int d = 0; d < ND; d++) begin
            instr[d]   = 32'd0;
            br[d]      = 1'b0;
            sc_exp[d]  = 32'd0;
            fc_exp[d]  = 32'd0;
            issue_d[d] = 1'b0;
            stall_d[d] = 1'b0;
            br_d[d]    = 1'b0;
            wd_d[d]    = 5'd0;
            for (int i = 0; i < LOGN; i++) dlog[d][i] = 5'd0;
        end
        cnt_max[0] = 32'hFFFF_FFFF;
        cnt_max[1] = 32'hFFFF_FFFF;
        cnt_max[2] = 32'd15;

        // power-on reset then a random mix with random redirects
        plist.delete();
        new_prog();
        run_phase(300, 0, 2, -1, 1'b1, 0);
        plist.delete();
        new_prog();
        run_phase(6, -1, 0, -1, 1'b0, 0);

        // async reset while the dependent add is stalled on x1 in EX
        plist.delete();
        plist.push_back(enc_i(OPIMM, 5'd1, 5'd0, 12'd5));
        plist.push_back(enc_r(5'd2, 5'd1, 5'd1));
        new_prog();
        run_phase(10, 1, 2, -1, 1'b0, 1);

        // back-to-back RAW: 2 stalls write-first, 3 with WB checked
        plist.delete();
        plist.push_back(enc_i(OPIMM, 5'd1, 5'd0, 12'd5));
        plist.push_back(enc_r(5'd2, 5'd1, 5'd1));
        new_prog();
        run_phase(12, -1, 0, -1, 1'b0, 0);
        chk("raw_stall_cnt", 0, scnt_o[0], 32'd2);
        chk("raw_stall_cnt", 1, scnt_o[1], 32'd3);
        chk("raw_stall_cnt", 2, scnt_o[2], 32'd2);

        // x0 writers/readers and non-users never stall; jal's offset bits alias x5 in the rs1 field
        plist.delete();
        plist.push_back(enc_i(OPIMM, 5'd0, 5'd0, 12'd1));
        plist.push_back(enc_r(5'd3, 5'd0, 5'd0));
        plist.push_back(enc_u(LUI, 5'd5, 20'h00001));
        plist.push_back(enc_u(JAL, 5'd6, 20'h00028));
        new_prog();
        run_phase(10, -1, 0, -1, 1'b0, 0);
        chk("x0_stall_cnt", 0, scnt_o[0], 32'd2);
        chk("x0_stall_cnt", 1, scnt_o[1], 32'd3);
        chk("x0_stall_cnt", 2, scnt_o[2], 32'd2);

        // redirect arrives while the ID instruction is blocked on x1
        plist.delete();
        plist.push_back(enc_i(OPIMM, 5'd1, 5'd0, 12'd5));
        plist.push_back(enc_r(5'd2, 5'd1, 5'd0));
        new_prog();
        run_phase(8, -1, 0, 1, 1'b0, 2);
        for (int d = 0; d < ND; d++) chk("redirect_flush_cnt", d, fcnt_o[d], 32'd1);

        // dependent chain keeps stalling; the 4-bit counter must pin at 15
        plist.delete();
        for (int i = 0; i < 12; i++) plist.push_back(enc_i(OPIMM, 5'd1, 5'd1, 12'd1));
        new_prog();
        run_phase(60, -1, 0, -1, 1'b0, 0);
        chk("sat_stall_cnt", 2, scnt_o[2], 32'd15);

        plist.delete();
        new_prog();
        run_phase(400, -1, 0, -1, 1'b1, 0);

        @(negedge i_clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
